// File: rtl/fm_audio_sequencer.sv
// rtl/fm_audio_sequencer.sv - audio sample pacing, source select and gain ramping for fm_modulator
`timescale 1ns/1ps
module fm_audio_sequencer #(
  parameter int A        = 8,
  parameter int TICK_DIV = 1000,
  parameter int G        = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         src_sel,
  input  logic [15:0]  tone_inc,
  input  logic [A-1:0] ext_data,
  input  logic         ext_valid,
  output logic         ext_ready,
  output logic [A-1:0] audio_out,
  output logic         sample_tick,
  output logic         underrun,
  output logic [1:0]   state
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [G:0] FULL_GAIN = {1'b1, {G{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DOWN = 2'd3} state_t;

  state_t         st, nxt_st;
  logic [CW-1:0]  cnt;
  logic [G:0]     gain, nxt_gain, up_gain;
  logic           active, nxt_active;
  logic [15:0]    phase;
  logic [A-1:0]   hold, last, sample;
  logic           full;
  logic           tick, accept, ext_turn, consume, sw, go_up, go_down;
  logic signed [A+G:0] prod;

  assign tick        = (cnt == CNT_LAST);
  assign sample_tick = tick;
  assign state       = st;
  assign ext_ready   = ~full;
  assign accept      = ext_valid & ~full;
  // The external stream is only drained while the sequencer is active on it.
  assign ext_turn    = tick & (st != IDLE) & ~active;
  assign consume     = ext_turn & full;
  assign underrun    = ext_turn & ~full;
  assign sw          = (src_sel != active);
  assign up_gain     = gain + 1'b1;

  always_comb begin
    sample = last;
    if (active)
      sample = phase[15:16-A];
    else if ((st != IDLE) && full)
      sample = hold;
  end

  always_comb begin
    nxt_st     = st;
    nxt_gain   = gain;
    nxt_active = active;
    go_up      = 1'b0;
    go_down    = 1'b0;
    case (st)
      IDLE: begin
        nxt_gain = '0;
        if (enable) begin
          nxt_active = src_sel;
          nxt_st     = RAMP_UP;
        end
      end
      RAMP_UP:   if (!enable || sw) go_down = 1'b1; else go_up = 1'b1;
      RUN:       if (!enable || sw) go_down = 1'b1; else nxt_gain = FULL_GAIN;
      RAMP_DOWN: if (enable && !sw) go_up = 1'b1; else go_down = 1'b1;
      default:   nxt_st = IDLE;
    endcase
    if (go_up) begin
      nxt_gain = up_gain;
      nxt_st   = (up_gain == FULL_GAIN) ? RUN : RAMP_UP;
    end
    // Ramp down steps one LSB per tick; the source may only change once silent.
    if (go_down) begin
      nxt_gain = (gain == '0) ? '0 : gain - 1'b1;
      if (nxt_gain == '0) begin
        if (enable) begin
          nxt_active = src_sel;
          nxt_st     = RAMP_UP;
        end else begin
          nxt_st = IDLE;
        end
      end else begin
        nxt_st = RAMP_DOWN;
      end
    end
  end

  assign prod = $signed(sample) * $signed({1'b0, nxt_gain});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      st        <= IDLE;
      gain      <= '0;
      active    <= 1'b0;
      phase     <= '0;
      hold      <= '0;
      last      <= '0;
      full      <= 1'b0;
      audio_out <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (consume) begin
        full <= 1'b0;
        last <= hold;
      end
      if (accept) begin
        full <= 1'b1;
        hold <= ext_data;
      end
      if (tick) begin
        st        <= nxt_st;
        gain      <= nxt_gain;
        active    <= nxt_active;
        phase     <= phase + tone_inc;
        audio_out <= A'(prod >>> G);
      end
    end
  end

endmodule

// File: tb/tb_fm_audio_sequencer.sv
// tb/tb_fm_audio_sequencer.sv - scoreboard bench for fm_audio_sequencer
`timescale 1ns/1ps
module tb_fm_audio_sequencer;
  localparam int A = 8, TD = 8, G = 4;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, src_sel = 1'b0, ext_valid = 1'b0;
  logic [15:0] tone_inc = '0;
  logic [7:0]  ext_data = '0;
  logic        ext_ready, sample_tick, underrun;
  logic [7:0]  audio_out;
  logic [1:0]  state;

  fm_audio_sequencer #(.A(A), .TICK_DIV(TD), .G(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .src_sel(src_sel), .tone_inc(tone_inc),
    .ext_data(ext_data), .ext_valid(ext_valid), .ext_ready(ext_ready), .audio_out(audio_out),
    .sample_tick(sample_tick), .underrun(underrun), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [7:0] audio; logic [1:0] st;} exp_t;
  exp_t sb[$];

  int          m_cnt, m_gain, tick_no;
  logic [1:0]  m_state;
  bit          m_active, m_full;
  logic [15:0] m_phase;
  logic [7:0]  m_hold, m_last, m_audio;

  task automatic model_reset();
    m_cnt = 0; m_gain = 0; m_state = 2'd0; m_active = 0; m_full = 0;
    m_phase = '0; m_hold = '0; m_last = '0; m_audio = '0;
    sb.delete();
  endtask

  task automatic model_edge();
    bit acc, cons, down, up;
    logic [7:0] samp;
    logic [1:0] ns;
    int g, s, p;
    acc = ext_valid && !m_full;
    cons = 0;
    if (m_cnt == TD - 1) begin
      if (m_active) samp = m_phase[15:8];
      else if (m_state != 2'd0 && m_full) begin samp = m_hold; m_last = m_hold; cons = 1; end
      else samp = m_last;
      g = m_gain; ns = m_state; up = 0; down = 0;
      case (m_state)
        2'd0: begin g = 0; if (enable) begin m_active = src_sel; ns = 2'd1; end end
        2'd1: if (!enable || src_sel != m_active) down = 1; else up = 1;
        2'd2: if (!enable || src_sel != m_active) down = 1; else g = 16;
        default: if (enable && src_sel == m_active) up = 1; else down = 1;
      endcase
      if (up) begin g = m_gain + 1; ns = (g == 16) ? 2'd2 : 2'd1; end
      if (down) begin
        g = (m_gain > 0) ? m_gain - 1 : 0;
        if (g == 0) begin
          if (enable) begin m_active = src_sel; ns = 2'd1; end else ns = 2'd0;
        end else ns = 2'd3;
      end
      s = $signed(samp);
      p = (s * g) >>> 4;
      m_audio = p[7:0];
      m_phase = m_phase + tone_inc;
      sb.push_back('{m_audio, ns});
      m_state = ns; m_gain = g; tick_no++;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_full = (m_full && !cons) || acc;
    if (acc) m_hold = ext_data;
  endtask

  task automatic step();
    exp_t e;
    bit exp_ur;
    exp_ur = (m_cnt == TD - 1) && (m_state != 2'd0) && !m_active && !m_full;
    check("sample_tick", sample_tick, m_cnt == TD - 1);
    check("underrun", underrun, exp_ur);
    check("ext_ready", ext_ready, !m_full);
    check("audio_stable", audio_out, m_audio);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("audio_tick", audio_out, e.audio);
      check("state_tick", state, e.st);
    end
  endtask

  task automatic run_ticks(input int n);
    int t0, guard;
    t0 = tick_no; guard = 0;
    while (tick_no < t0 + n && guard < (n + 1) * TD) begin step(); guard++; end
    check("tick_budget", tick_no - t0, n);
  endtask

  task automatic to_tick();
    int guard;
    guard = 0;
    while (m_cnt != TD - 1 && guard < 2 * TD) begin step(); guard++; end
    check("to_tick", sample_tick, 1);
  endtask

  initial begin
    int n;
    model_reset();
    tick_no = 0;
    @(negedge clk);
    check("rst_audio", audio_out, 8'h00);
    check("rst_state", state, 2'd0);
    check("rst_ready", ext_ready, 1);
    check("rst_tick", sample_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Ramp up on a constant external stream
    ext_data = 8'h40; ext_valid = 1; src_sel = 0; enable = 1;
    run_ticks(17);
    check("rampup_state", state, 2'd2);
    check("rampup_audio", audio_out, 8'h40);

    // Starve the stream while running
    ext_valid = 0;
    run_ticks(3);
    check("starve_audio", audio_out, 8'h40);
    to_tick();
    check("starve_underrun", underrun, 1);

    // Switch to the tone: ramp down, relatch, ramp up
    tone_inc = 16'h0100; src_sel = 1;
    run_ticks(16);
    check("switch_state", state, 2'd1);
    check("switch_audio", audio_out, 8'h00);
    run_ticks(16);
    check("tone_state", state, 2'd2);
    check("tone_audio", audio_out, 8'h1f);

    // Drop enable partway through a ramp, then raise it partway down
    enable = 0; run_ticks(16);
    check("off_state", state, 2'd0);
    enable = 1; run_ticks(6);
    check("g5_state", state, 2'd1);
    enable = 0; run_ticks(5);
    check("g5_down_idle", state, 2'd0);
    enable = 1; run_ticks(6);
    enable = 0; run_ticks(3);
    check("g2_state", state, 2'd3);
    enable = 1; run_ticks(1);
    check("g2_reup", state, 2'd1);

    // Random traffic and control toggling
    for (int i = 0; i < 80 * TD; i++) begin
      ext_valid = 1'($urandom_range(0, 1));
      ext_data  = 8'($urandom);
      if (i % TD == 0) begin
        if ($urandom_range(0, 3) == 0) enable = ~enable;
        if ($urandom_range(0, 7) == 0) src_sel = ~src_sel;
        if ($urandom_range(0, 5) == 0) tone_inc = 16'($urandom);
      end
      step();
    end

    // Sample offered in the tick cycle with the hold empty
    ext_valid = 0; enable = 1; src_sel = 0;
    run_ticks(40);
    check("ext_run_state", state, 2'd2);
    to_tick();
    ext_data = 8'h80; ext_valid = 1;
    check("late_underrun", underrun, 1);
    step();
    ext_valid = 0;
    check("late_held", ext_ready, 0);
    run_ticks(1);
    check("late_audio", audio_out, 8'h80);

    // Asynchronous reset in the middle of RUN
    run_ticks(2);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    check("arst_audio", audio_out, 8'h00);
    check("arst_state", state, 2'd0);
    check("arst_ready", ext_ready, 1);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!sample_tick && n < 20) begin step(); n++; end
    check("first_tick", n, 7);
    run_ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
